// File: rtl/mainm_arbiter.sv
// mainm_arbiter: shares the single main-memory port between the CPU/MMU path
// (port 0) and a DMA-style master (port 1). Only one transaction is in flight
// at a time. Arbitration is either round-robin or fixed priority with port 0
// winning. A watchdog forces completion of a transaction that has hung.
module mainm_arbiter #(
    parameter bit          RR_EN          = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter logic [31:0] TIMEOUT_DATA   = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        rst_n,
    // port 0: CPU / MMU path
    input  logic [31:0] m0_a,
    input  logic [31:0] m0_d,
    input  logic        m0_we,
    input  logic        m0_rd,
    output logic [31:0] m0_spo,
    output logic        m0_ready,
    // port 1: video fetch / serial boot
    input  logic [31:0] m1_a,
    input  logic [31:0] m1_d,
    input  logic        m1_we,
    input  logic        m1_rd,
    output logic [31:0] m1_spo,
    output logic        m1_ready,
    // memory controller side
    output logic [31:0] mem_a,
    output logic [31:0] mem_d,
    output logic        mem_we,
    output logic        mem_rd,
    input  logic [31:0] mem_spo,
    input  logic        mem_ready,
    // status
    output logic [1:0]  grant,
    output logic        irq,
    input  logic        irq_clr
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // The watchdog fires while the timer holds the last allowed BUSY count.
    localparam bit          TIMER_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    logic [31:0] r_mem_a;
    logic [31:0] r_mem_d;
    logic        r_mem_we;
    logic        r_mem_rd;
    logic [1:0]  r_grant;
    logic        r_last_grant;   // index of the port served last
    logic [15:0] r_timer;
    logic [31:0] r_m0_spo;
    logic [31:0] r_m1_spo;
    logic        r_m0_ready;
    logic        r_m1_ready;
    logic        r_irq;

    logic        w_req0;
    logic        w_req1;
    logic        w_pick1;
    logic [31:0] w_sel_a;
    logic [31:0] w_sel_d;
    logic        w_sel_we;
    logic        w_sel_rd;
    logic        w_timeout;
    logic        w_finish;
    logic        w_to_fire;
    logic [31:0] w_done_data;

    assign w_req0 = m0_we | m0_rd;
    assign w_req1 = m1_we | m1_rd;

    // Winner selection: a lone requester wins; a tie goes to the port that
    // was not served last (round-robin) or always to port 0 (fixed priority).
    always_comb begin
        // NOTE: assign a default first so every path drives the signal and no latch is inferred.
        w_pick1 = 1'b0;
        if (w_req0 && w_req1) begin
            w_pick1 = RR_EN ? ~r_last_grant : 1'b0;
        end else begin
            w_pick1 = w_req1;
        end
    end

    // A request with both we and rd high is treated as a write.
    assign w_sel_a  = w_pick1 ? m1_a  : m0_a;
    assign w_sel_d  = w_pick1 ? m1_d  : m0_d;
    assign w_sel_we = w_pick1 ? m1_we : m0_we;
    assign w_sel_rd = (w_pick1 ? m1_rd : m0_rd) & ~w_sel_we;

    assign w_timeout   = TIMER_EN && (r_timer == TIMER_LAST);
    assign w_finish    = (r_state == ST_BUSY) && (mem_ready || w_timeout);
    assign w_to_fire   = (r_state == ST_BUSY) && !mem_ready && w_timeout;
    assign w_done_data = mem_ready ? mem_spo : TIMEOUT_DATA;

    // Transaction sequencer: IDLE picks a winner, BUSY holds the memory
    // strobes until completion or watchdog expiry, DONE is a one-cycle bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_mem_a      <= '0;
            r_mem_d      <= '0;
            r_mem_we     <= 1'b0;
            r_mem_rd     <= 1'b0;
            r_grant      <= 2'b00;
            r_last_grant <= 1'b1;
            r_timer      <= '0;
            r_m0_spo     <= '0;
            r_m1_spo     <= '0;
            r_m0_ready   <= 1'b0;
            r_m1_ready   <= 1'b0;
        end else begin
            // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
            r_m0_ready <= 1'b0;
            r_m1_ready <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_req0 || w_req1) begin
                        r_mem_a      <= w_sel_a;
                        r_mem_d      <= w_sel_d;
                        r_mem_we     <= w_sel_we;
                        r_mem_rd     <= w_sel_rd;
                        r_grant      <= w_pick1 ? 2'b10 : 2'b01;
                        r_last_grant <= w_pick1;
                        r_timer      <= '0;
                        r_state      <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (w_finish) begin
                        r_mem_we <= 1'b0;
                        r_mem_rd <= 1'b0;
                        if (r_grant[1]) begin
                            r_m1_ready <= 1'b1;
                            if (r_mem_rd) begin
                                r_m1_spo <= w_done_data;
                            end
                        end else begin
                            r_m0_ready <= 1'b1;
                            if (r_mem_rd) begin
                                r_m0_spo <= w_done_data;
                            end
                        end
                        r_state <= ST_DONE;
                    end else if (r_timer != 16'hFFFF) begin
                        r_timer <= r_timer + 16'd1;
                    end
                end
                ST_DONE: begin
                    r_grant <= 2'b00;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Sticky timeout flag; a timeout in the same cycle as irq_clr keeps it set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq <= 1'b0;
        end else if (w_to_fire) begin
            r_irq <= 1'b1;
        end else if (irq_clr) begin
            r_irq <= 1'b0;
        end
    end

    assign mem_a    = r_mem_a;
    assign mem_d    = r_mem_d;
    assign mem_we   = r_mem_we;
    assign mem_rd   = r_mem_rd;
    assign grant    = r_grant;
    assign m0_spo   = r_m0_spo;
    assign m1_spo   = r_m1_spo;
    assign m0_ready = r_m0_ready;
    assign m1_ready = r_m1_ready;
    assign irq      = r_irq;

endmodule

// File: tb/tb_mainm_arbiter.sv
// tb_mainm_arbiter: random masters and a random-latency memory drive a
// round-robin instance with a 16-cycle watchdog; a transaction-level model
// predicts every output each cycle. A second, fixed-priority instance with
// the watchdog disabled is driven by two permanently requesting masters.
`timescale 1ns/1ps
module tb_mainm_arbiter;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] m0_a, m0_d, m1_a, m1_d, mem_spo;
    logic        m0_we, m0_rd, m1_we, m1_rd, mem_ready, irq_clr;
    logic [31:0] m0_spo, m1_spo, mem_a, mem_d;
    logic        m0_ready, m1_ready, mem_we, mem_rd, irq;
    logic [1:0]  grant;

    logic        f_rst_n;
    logic [31:0] f_m0_a, f_m0_d, f_m1_a, f_m1_d, f_mem_spo;
    logic        f_m0_we, f_m0_rd, f_m1_we, f_m1_rd, f_mem_ready, f_irq_clr;
    logic [31:0] f_m0_spo, f_m1_spo, f_mem_a, f_mem_d;
    logic        f_m0_ready, f_m1_ready, f_mem_we, f_mem_rd, f_irq;
    logic [1:0]  f_grant;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mainm_arbiter #(.RR_EN(1'b1), .TIMEOUT_CYCLES(TO), .TIMEOUT_DATA(32'hDEADBEEF)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .m0_a(m0_a), .m0_d(m0_d), .m0_we(m0_we), .m0_rd(m0_rd), .m0_spo(m0_spo), .m0_ready(m0_ready),
        .m1_a(m1_a), .m1_d(m1_d), .m1_we(m1_we), .m1_rd(m1_rd), .m1_spo(m1_spo), .m1_ready(m1_ready),
        .mem_a(mem_a), .mem_d(mem_d), .mem_we(mem_we), .mem_rd(mem_rd),
        .mem_spo(mem_spo), .mem_ready(mem_ready),
        .grant(grant), .irq(irq), .irq_clr(irq_clr)
    );

    mainm_arbiter #(.RR_EN(1'b0), .TIMEOUT_CYCLES(0), .TIMEOUT_DATA(32'hDEADBEEF)) u_fp (
        .clk(clk), .rst_n(f_rst_n),
        .m0_a(f_m0_a), .m0_d(f_m0_d), .m0_we(f_m0_we), .m0_rd(f_m0_rd), .m0_spo(f_m0_spo), .m0_ready(f_m0_ready),
        .m1_a(f_m1_a), .m1_d(f_m1_d), .m1_we(f_m1_we), .m1_rd(f_m1_rd), .m1_spo(f_m1_spo), .m1_ready(f_m1_ready),
        .mem_a(f_mem_a), .mem_d(f_mem_d), .mem_we(f_mem_we), .mem_rd(f_mem_rd),
        .mem_spo(f_mem_spo), .mem_ready(f_mem_ready),
        .grant(f_grant), .irq(f_irq), .irq_clr(f_irq_clr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    typedef enum {PH_IDLE, PH_BUSY, PH_DONE} phase_t;
    phase_t      ph;
    bit          owner, last_win, ex_we, ex_irq;
    logic [31:0] ex_a, ex_d;
    logic [31:0] ex_spo[2];
    bit   [1:0]  ex_rdy;
    int          cnt;

    // inputs that were applied during the cycle that just ended
    bit   [1:0]  p_we, p_rd;
    logic [31:0] p_a[2], p_d[2];
    bit          p_mrdy, p_clr;
    logic [31:0] p_mspo;

    // master agents
    bit          ag_act[2], ag_we[2], ag_rd[2];
    logic [31:0] ag_a[2], ag_d[2];
    int          ag_wait[2];

    // memory responder
    bit          m_prev_str, first_txn;
    int          m_wait;

    task automatic model_reset();
        ph = PH_IDLE; owner = 1'b0; last_win = 1'b1; ex_we = 1'b0; ex_irq = 1'b0;
        ex_a = '0; ex_d = '0; ex_spo[0] = '0; ex_spo[1] = '0; ex_rdy = 2'b00; cnt = 0;
        m_prev_str = 1'b0; m_wait = -1;
    endtask

    task automatic model_update();
        bit [1:0] req;
        bit       w;
        bit       to_fire;
        req = p_we | p_rd;
        to_fire = 1'b0;
        ex_rdy = 2'b00;
        case (ph)
            PH_IDLE: if (req != 2'b00) begin
                if (req == 2'b11) w = ~last_win;
                else              w = req[1];
                owner = w; last_win = w;
                ex_a = p_a[w]; ex_d = p_d[w]; ex_we = p_we[w];
                cnt = 0; ph = PH_BUSY;
            end
            PH_BUSY: begin
                if (p_mrdy) begin
                    ph = PH_DONE; ex_rdy[owner] = 1'b1;
                    if (!ex_we) ex_spo[owner] = p_mspo;
                end else if (cnt == TO - 1) begin
                    ph = PH_DONE; ex_rdy[owner] = 1'b1; to_fire = 1'b1;
                    if (!ex_we) ex_spo[owner] = 32'hDEADBEEF;
                end else begin
                    cnt++;
                end
            end
            default: ph = PH_IDLE;
        endcase
        if (to_fire)    ex_irq = 1'b1;
        else if (p_clr) ex_irq = 1'b0;
    endtask

    task automatic compare_outputs();
        logic [1:0] eg;
        eg = (ph == PH_IDLE) ? 2'b00 : (owner ? 2'b10 : 2'b01);
        check("grant", grant, eg);
        check("m0_ready", m0_ready, ex_rdy[0]);
        check("m1_ready", m1_ready, ex_rdy[1]);
        check("m0_spo", m0_spo, ex_spo[0]);
        check("m1_spo", m1_spo, ex_spo[1]);
        check("irq", irq, ex_irq);
        check("mem_we", mem_we, (ph == PH_BUSY) && ex_we);
        check("mem_rd", mem_rd, (ph == PH_BUSY) && !ex_we);
        if (ph == PH_BUSY) begin
            check("mem_a", mem_a, ex_a);
            check("mem_d", mem_d, ex_d);
        end
    endtask

    task automatic start_txn(input int p);
        int unsigned r;
        r = $urandom_range(0, 3);
        ag_act[p] = 1'b1;
        ag_we[p]  = (r == 0) || (r == 3);
        ag_rd[p]  = (r != 0);
        ag_a[p]   = $urandom;
        ag_d[p]   = $urandom;
    endtask

    // Agents react to observed ready pulses, the memory reacts to observed
    // strobes, then the next cycle's inputs are applied and remembered.
    task automatic stimulate();
        bit          str, mis, mrdy;
        logic [31:0] mspo;
        bit   [1:0]  dwe, drd;
        logic [31:0] da[2], dd[2];
        int unsigned r;
        bit   [1:0]  obs;
        obs = {m1_ready, m0_ready};
        for (int p = 0; p < 2; p++) begin
            if (ag_act[p]) begin
                if (obs[p]) begin
                    ag_act[p] = 1'b0;
                    ag_wait[p] = $urandom_range(0, 3);
                end
            end else if (ag_wait[p] > 0) begin
                ag_wait[p]--;
            end else if ($urandom_range(0, 1) == 1) begin
                start_txn(p);
            end
            // the owning master may misbehave mid-transaction; this must be ignored
            mis = (ph == PH_BUSY) && (owner == p[0]) && ($urandom_range(0, 3) == 0);
            dwe[p] = ag_act[p] && ag_we[p] && !mis;
            drd[p] = ag_act[p] && ag_rd[p] && !mis;
            da[p]  = mis ? $urandom : ag_a[p];
            dd[p]  = mis ? $urandom : ag_d[p];
        end
        str = mem_we | mem_rd;
        mspo = $urandom;
        mrdy = 1'b0;
        if (str) begin
            if (!m_prev_str) begin
                if (first_txn) begin
                    m_wait = 5;
                end else begin
                    r = $urandom_range(0, 9);
                    m_wait = (r <= 6) ? int'(r) : ((r == 7) ? 15 : 99);
                end
            end
            if (m_wait == 0) begin
                mrdy = 1'b1;
                if (first_txn) mspo = 32'h12345678;
                first_txn = 1'b0;
                m_wait = -1;
            end else if (m_wait > 0) begin
                m_wait--;
            end
        end else begin
            mrdy = ($urandom_range(0, 3) == 0);   // stray/late ready, must be ignored
        end
        m_prev_str = str;
        if ((ph == PH_BUSY) && (cnt == TO - 1) && !mrdy) p_clr = ($urandom_range(0, 1) == 1);
        else                                           p_clr = ($urandom_range(0, 15) == 0);
        m0_we = dwe[0]; m0_rd = drd[0]; m0_a = da[0]; m0_d = dd[0];
        m1_we = dwe[1]; m1_rd = drd[1]; m1_a = da[1]; m1_d = dd[1];
        mem_ready = mrdy; mem_spo = mspo; irq_clr = p_clr;
        p_we = dwe; p_rd = drd; p_a = da; p_d = dd; p_mrdy = mrdy; p_mspo = mspo;
    endtask

    task automatic step();
        model_update();
        compare_outputs();
        stimulate();
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, " grant"}, grant, 0);
        check({pfx, " m0_ready"}, m0_ready, 0);
        check({pfx, " m1_ready"}, m1_ready, 0);
        check({pfx, " m0_spo"}, m0_spo, 0);
        check({pfx, " m1_spo"}, m1_spo, 0);
        check({pfx, " mem_a"}, mem_a, 0);
        check({pfx, " mem_d"}, mem_d, 0);
        check({pfx, " mem_we"}, mem_we, 0);
        check({pfx, " mem_rd"}, mem_rd, 0);
        check({pfx, " irq"}, irq, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int          f_wait, n_pulse, n_rdy0, busy_wait;
        bit          f_prev_str, f_pulse_prev, f_first, str, pulse;
        logic [31:0] f_last_spo;

        rst_n = 1'b0; f_rst_n = 1'b0;
        m0_a = '0; m0_d = '0; m0_we = 0; m0_rd = 0;
        m1_a = '0; m1_d = '0; m1_we = 0; m1_rd = 0;
        mem_spo = '0; mem_ready = 0; irq_clr = 0;
        f_m0_a = '0; f_m0_d = '0; f_m0_we = 0; f_m0_rd = 0;
        f_m1_a = '0; f_m1_d = '0; f_m1_we = 0; f_m1_rd = 0;
        f_mem_spo = '0; f_mem_ready = 0; f_irq_clr = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");

        // first transaction: lone read on port 0, memory answers with a fixed word
        model_reset();
        first_txn = 1'b1;
        ag_act[0] = 1'b1; ag_we[0] = 1'b0; ag_rd[0] = 1'b1;
        ag_a[0] = 32'h80000010; ag_d[0] = 32'h0;
        ag_act[1] = 1'b0; ag_wait[0] = 0; ag_wait[1] = 15;
        m0_rd = 1'b1; m0_a = 32'h80000010;
        p_we = 2'b00; p_rd = 2'b01; p_a[0] = 32'h80000010; p_a[1] = '0;
        p_d[0] = '0; p_d[1] = '0; p_mrdy = 1'b0; p_mspo = '0; p_clr = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            step();
        end

        // reset asserted in the middle of a transaction
        busy_wait = 0;
        do begin
            @(negedge clk);
            step();
            busy_wait++;
        end while (!(ph == PH_BUSY && cnt >= 2) && busy_wait < 200);
        check("reach busy before reset", busy_wait < 200, 1);
        #2 rst_n = 1'b0;
        #1 check_all_zero("async reset");
        @(negedge clk);
        check_all_zero("in reset");
        model_reset();
        start_txn(0); start_txn(1);
        m0_we = ag_we[0]; m0_rd = ag_rd[0]; m0_a = ag_a[0]; m0_d = ag_d[0];
        m1_we = ag_we[1]; m1_rd = ag_rd[1]; m1_a = ag_a[1]; m1_d = ag_d[1];
        mem_ready = 1'b0; irq_clr = 1'b0;
        p_we = {ag_we[1], ag_we[0]}; p_rd = {ag_rd[1], ag_rd[0]};
        p_a[0] = ag_a[0]; p_a[1] = ag_a[1]; p_d[0] = ag_d[0]; p_d[1] = ag_d[1];
        p_mrdy = 1'b0; p_clr = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        step();
        check("tie after reset grant", grant, 2'b01);
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            step();
        end

        // fixed-priority instance, both ports requesting permanently
        @(negedge clk);
        f_rst_n = 1'b1;
        f_m0_rd = 1'b1; f_m1_rd = 1'b1;
        f_m0_a = 32'h100; f_m1_a = 32'h200;
        f_prev_str = 0; f_pulse_prev = 0; f_first = 1; f_wait = -1;
        n_pulse = 0; n_rdy0 = 0; f_last_spo = '0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            check("fp m0_ready", f_m0_ready, f_pulse_prev);
            check("fp m1_ready", f_m1_ready, 0);
            check("fp grant port1", f_grant[1], 0);
            check("fp irq", f_irq, 0);
            if (f_m0_ready) begin
                n_rdy0++;
                check("fp m0_spo", f_m0_spo, f_last_spo);
            end
            str = f_mem_rd | f_mem_we;
            if (str) check("fp mem_a", f_mem_a, 32'h100);
            if (str && !f_prev_str) begin
                f_wait = f_first ? 30 : int'($urandom_range(0, 3));
                f_first = 1'b0;
            end
            pulse = 1'b0;
            if (str && f_wait == 0 && i < 290) begin
                pulse = 1'b1;
                f_wait = -1;
            end else if (str && f_wait > 0) begin
                f_wait--;
            end
            f_mem_ready = pulse;
            f_mem_spo = $urandom;
            if (pulse) begin
                n_pulse++;
                f_last_spo = f_mem_spo;
            end
            f_pulse_prev = pulse;
            f_prev_str = str;
        end
        check("fp completions", n_rdy0, n_pulse);
        check("fp progress", n_pulse >= 10, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
